// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and helpers for the lock-on-transaction arbiters.
//   MODE_FIXED / MODE_RR : values of the mode_rr select input
//   arb_state_e          : arbiter FSM states (ST_IDLE, ST_BUSY)
//   onehot2idx()         : binary index of a one-hot vector (up to 32 bits)
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Returns the index of the set bit; an all-zero vector maps to 0.
    function automatic logic [4:0] onehot2idx(input logic [31:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (oh[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_lock_arbiter_if.sv
// -----------------------------------------------------------------------------
// rr_lock_arbiter_if
// Request/grant bundle between requesters, downstream sink and the arbiter.
//   req, req_last   : per-requester request level and last-beat flag
//   mode_rr         : 0 = fixed priority, 1 = round-robin
//   gnt_ready       : downstream accepts the current beat
//   grant           : one-hot grant
//   grant_idx       : binary grant index, valid with grant_valid
//   grant_valid     : a grant is active
//   timeout         : one-cycle forced-release pulse
// Modports: master (requester/system side), slave (arbiter side).
// -----------------------------------------------------------------------------
interface rr_lock_arbiter_if #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) ();

    logic [N-1:0]  req;
    logic [N-1:0]  req_last;
    logic          mode_rr;
    logic          gnt_ready;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_idx;
    logic          grant_valid;
    logic          timeout;

    modport master (
        output req, req_last, mode_rr, gnt_ready,
        input  grant, grant_idx, grant_valid, timeout
    );

    modport slave (
        input  req, req_last, mode_rr, gnt_ready,
        output grant, grant_idx, grant_valid, timeout
    );

endinterface

// File: rtl/arb_rr_pick.sv
// -----------------------------------------------------------------------------
// arb_rr_pick
// Combinational winner selection.
//   req     : request vector
//   ptr     : index of the last winner (round-robin mode only)
//   mode    : MODE_FIXED = lowest set index wins,
//             MODE_RR    = first set bit strictly above ptr, wrapping to 0
//   win_idx : winning index (0 when win_vld is low)
//   win_vld : at least one request is present
// -----------------------------------------------------------------------------
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          mode,
    output logic [IW-1:0] win_idx,
    output logic          win_vld
);

    logic [2*N-1:0] w_dbl;
    int unsigned    w_ptr_u;

    always_comb begin
        // Two copies of req side by side: the window (ptr, ptr+N] covers every
        // requester exactly once starting just above ptr, so a plain lowest-bit
        // encode over that window gives the wrapped round-robin winner.
        w_dbl   = {req, req};
        w_ptr_u = 32'(ptr);
        win_idx = '0;
        win_vld = |req;
        if (mode == MODE_RR) begin
            for (int unsigned j = 2 * N - 1; j >= 1; j--) begin
                if (w_dbl[j] && (j > w_ptr_u) && (j <= w_ptr_u + N)) begin
                    win_idx = IW'((j >= N) ? (j - N) : j);
                end
            end
        end else begin
            for (int unsigned i = N; i > 0; i--) begin
                if (req[i-1]) win_idx = IW'(i - 1);
            end
        end
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// -----------------------------------------------------------------------------
// rr_lock_arbiter
// N-way arbiter, fixed priority or round-robin selectable at runtime. The grant
// is registered one-hot and stays locked on the winner until its transaction
// completes (gnt_ready && req_last[grant_idx]) or the winner drops its request.
// On release a new winner is registered on the next edge with no idle bubble.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : rr_lock_arbiter_if.slave (req/req_last/mode_rr/gnt_ready in,
//          grant/grant_idx/grant_valid/timeout out)
// Optional feature macro: ARB_HOLD_TIMEOUT_EN
//   defined   : a grant held HOLD_MAX cycles without completing is force-
//               released and timeout pulses for one cycle
//   undefined : no hold counter, timeout is constant 0
// -----------------------------------------------------------------------------
module rr_lock_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int IW       = $clog2(N),
    parameter int HOLD_MAX = 64
) (
    input  logic               clk,
    input  logic               rst,
    rr_lock_arbiter_if.slave   bus
);

    if ((N < 2) || (N > 32) || (HOLD_MAX < 2)) begin : g_bad_cfg
        $error("rr_lock_arbiter: N must be 2..32 and HOLD_MAX at least 2");
    end

    arb_state_e    r_state;
    logic [N-1:0]  r_grant;
    logic [IW-1:0] r_grant_idx;
    logic [IW-1:0] r_rr_ptr;
    logic          r_grant_valid;

    logic          w_rr;
    logic          w_done;
    logic          w_abort;
    logic          w_to;
    logic          w_release;
    logic          w_load;
    logic [IW-1:0] w_ptr;
    logic [IW-1:0] w_win_idx;
    logic          w_win_vld;

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int HW = $clog2(HOLD_MAX + 1);
    logic [HW-1:0] r_hold;
    logic          r_timeout;
`endif

    always_comb begin
        w_rr    = (bus.mode_rr == MODE_RR);
        w_done  = bus.gnt_ready & bus.req_last[r_grant_idx];
        w_abort = ~bus.req[r_grant_idx];
`ifdef ARB_HOLD_TIMEOUT_EN
        w_to    = (r_hold == HW'(HOLD_MAX - 1));
`else
        w_to    = 1'b0;
`endif
        w_release = (r_state == ST_BUSY) & (w_abort | w_done | w_to);
        // On a release the pointer update must already be visible to this
        // cycle's re-arbitration, so the retiring index is fed through here.
        w_ptr  = (w_release & w_rr) ? r_grant_idx : r_rr_ptr;
        w_load = w_win_vld & ((r_state == ST_IDLE) | w_release);
    end

    arb_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req     (bus.req),
        .ptr     (w_ptr),
        .mode    (bus.mode_rr),
        .win_idx (w_win_idx),
        .win_vld (w_win_vld)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_rr_ptr      <= IW'(N - 1);
`ifdef ARB_HOLD_TIMEOUT_EN
            r_hold        <= '0;
            r_timeout     <= 1'b0;
`endif
        end else begin
            if (w_release && w_rr) r_rr_ptr <= r_grant_idx;
`ifdef ARB_HOLD_TIMEOUT_EN
            // Pulse only when the counter alone caused the release.
            r_timeout <= w_release & w_to & ~w_done & ~w_abort;
`endif
            if (w_load) begin
                r_state       <= ST_BUSY;
                r_grant       <= N'(1) << w_win_idx;
                r_grant_idx   <= w_win_idx;
                r_grant_valid <= 1'b1;
`ifdef ARB_HOLD_TIMEOUT_EN
                r_hold        <= '0;
`endif
            end else if (w_release) begin
                r_state       <= ST_IDLE;
                r_grant       <= '0;
                r_grant_idx   <= '0;
                r_grant_valid <= 1'b0;
            end else if (r_state == ST_BUSY) begin
`ifdef ARB_HOLD_TIMEOUT_EN
                r_hold        <= r_hold + 1'b1;
`endif
            end
        end
    end

    assign bus.grant       = r_grant;
    assign bus.grant_idx   = r_grant_idx;
    assign bus.grant_valid = r_grant_valid;
`ifdef ARB_HOLD_TIMEOUT_EN
    assign bus.timeout     = r_timeout;
`else
    assign bus.timeout     = 1'b0;
`endif

endmodule

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- Parametrised N-way arbiter with registered one-hot grant and a runtime-selectable mode: fixed priority (index 0 highest) or round-robin.
- Generalises the fixed-priority arbiter: the grant locks onto the winner until its transaction completes, via a ready handshake and a per-requester last flag.
- Sits in front of shared buses and shared memory ports.

Parameters:
- N, 4, number of requesters (2..32).
- IW, $clog2(N), width of the grant index.
- HOLD_MAX, 64, maximum cycles a grant may be held; used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  N  per-requester request level.
- req_last  in  N  per-requester "final beat of transaction" flag; sampled only for the granted index.
- mode_rr  in  1  0 = fixed priority, 1 = round-robin; sampled at arbitration.
- gnt_ready  in  1  downstream accepts the current beat.
- grant  out  N  registered one-hot grant.
- grant_idx  out  IW  binary index of grant; valid when grant_valid.
- grant_valid  out  1  a grant is active.
- timeout  out  1  one-cycle pulse on forced release; tied 0 without the optional feature.

Behaviour:
- Reset (rst=0, asynchronous): grant=0, grant_idx=0, grant_valid=0, timeout=0, state=IDLE, rr_ptr=N-1 so index 0 wins the first RR arbitration.
- States: IDLE and BUSY.
- IDLE:
  - If |req, compute the winner combinationally and register it: grant=onehot(win), grant_idx=win, grant_valid=1, go to BUSY.
  - Latency from req asserting to grant visible is 1 cycle.
- Winner rule:
  - Fixed mode: lowest set index of req.
  - RR mode: first set bit scanning upward from rr_ptr+1 modulo N, wrapping past N-1 to 0.
- BUSY, grant held constant while none of the exits below occurs.
- Completion: gnt_ready && req_last[grant_idx] in the same cycle.
  - In RR mode, rr_ptr <= grant_idx.
  - If |req at that cycle, re-arbitrate in the same cycle and register the new winner on the next edge (back-to-back, zero bubble).
  - Otherwise go to IDLE with grant=0 and grant_valid=0.
  - The completing requester is still eligible when its req is high; in RR mode it has the lowest priority after the pointer update.
- Abort: req[grant_idx]=0 while BUSY.
  - Handled exactly like completion, including the rr_ptr update.
  - Abort has priority over a simultaneous completion; the result is identical either way.
- Signals outside the grant: req_last of non-granted requesters and gnt_ready are ignored in IDLE.
- Mode change: a change on mode_rr mid-transaction has no effect until the next arbitration. rr_ptr is not updated in fixed mode.
- Single requester: N cycles of req with req_last each cycle gives a continuous grant, re-registered every cycle, with no gap.
- Reset mid-transaction: grant drops immediately (asynchronously); no completion is reported.

Optional Feature:
- Macro: ARB_HOLD_TIMEOUT_EN.
- Defined:
  - A hold counter (width $clog2(HOLD_MAX+1)) clears on every new grant and increments each BUSY cycle.
  - When it reaches HOLD_MAX-1 without a completion, the grant is force-released like a completion, rr_ptr advances and timeout pulses for 1 cycle, aligned with the first cycle after release.
  - A completion in the same cycle takes precedence; no timeout pulse is produced.
- Not defined: no counter is built; timeout is a constant 0; a grant may be held indefinitely.

Decomposition:
- Package arb_pkg:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1.
  - State encoding ST_IDLE and ST_BUSY.
  - Function onehot2idx.
- Sub-module arb_rr_pick, purely combinational:
  - Inputs: req, ptr, mode.
  - Outputs: win_idx, win_vld.
  - Implements the double-width mask/priority-encode for RR and the plain priority encode for fixed mode.
  - Reusable by other arbiters.

Test Plan:
- N=4, mode_rr=0, req=4'b1010, gnt_ready=1, req_last=4'b1111 held -> grant=0010 every cycle after 1-cycle latency; requester 3 is starved by design.
- mode_rr=1, req=4'b1111, req_last pulsed with gnt_ready every 3rd cycle -> grants rotate 0001, 0010, 0100, 1000, 0001, each held 3 cycles, with no idle gap between them.
- mode_rr=1, grant on idx 2, req[2] dropped mid-transaction with req=4'b1011 -> next grant 1000 (wraps past 2), grant_valid continuous.
- Grant on idx 1, gnt_ready=0 for 10 cycles, req_last[1]=1 -> grant stays 0010; with gnt_ready=1 for one cycle, release occurs on the next edge.
- Assert rst=0 asynchronously mid-BUSY -> grant=0 and grant_valid=0 before the next clk edge; after release, the first RR grant goes to index 0 when req=4'b1111.
- ARB_HOLD_TIMEOUT_EN defined, HOLD_MAX=8, idx 0 granted, req_last=0 -> grant released after 8 cycles held, timeout=1 for one cycle, next grant 0010 when req=4'b0011 in RR mode.
